// File: rtl/i2d_core_pkg.sv
// Shared core types for the fetch/decode boundary.
//   ifq_entry_t       : one fetched instruction (PC plus instruction word)
//   IFQ_DEPTH_DEFAULT : default instruction fetch queue depth
package i2d_core_pkg;

  localparam int unsigned IFQ_DEPTH_DEFAULT = 4;
  localparam int unsigned XLEN              = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifq_entry_t;

  localparam int unsigned IFQ_ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/i2d_sync_fifo.sv
// Generic synchronous FIFO with an in-order read port and a synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   clear    : empties the FIFO on the next edge, overriding wr_en/rd_en
//   wr_en    : write wr_data at the tail (caller guarantees not full)
//   rd_en    : drop the head entry (caller guarantees not empty)
//   rd_data  : head entry, read combinationally
//   count    : current occupancy, 0..DEPTH
module i2d_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // Storage is reset so the head read never propagates X.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en && !clear) mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/core_ifq.sv
// Instruction fetch queue between fetch and decode.
//   clk, rst           : clock and synchronous active-high reset
//   if_pc, if_instr    : completed fetch payload, valid when if_busy=0
//   if_busy            : fetch not complete this cycle
//   if_halt            : queue full, fetch must stall
//   flush              : redirect; drops queue contents and this cycle's fetch
//   id_valid/id_ready  : decode handshake on the head entry
//   id_pc, id_instr    : head entry payload
//   ifq_count          : current occupancy
module core_ifq
  import i2d_core_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            if_pc,
  input  logic [31:0]            if_instr,
  input  logic                   if_busy,
  output logic                   if_halt,
  input  logic                   flush,
  output logic                   id_valid,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_instr,
  input  logic                   id_ready,
  output logic [$clog2(DEPTH):0] ifq_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ifq_entry_t       wr_entry;
  ifq_entry_t       rd_entry;
  logic [CNT_W-1:0] count;
  logic             full_c;
  logic             push_c;
  logic             pop_c;

  // Status comes only from registered occupancy, so halt has no path from id_ready/if_busy.
  assign full_c   = (count == CNT_W'(DEPTH));
  assign id_valid = (count != '0);
  assign if_halt  = full_c;

  // A fetch arriving while full is dropped; flush overrides both sides.
  assign push_c = !if_busy && !flush && !full_c;
  assign pop_c  = id_valid && id_ready && !flush;

  assign wr_entry.pc    = if_pc;
  assign wr_entry.instr = if_instr;

  i2d_sync_fifo #(
    .WIDTH (IFQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .wr_en   (push_c),
    .wr_data (wr_entry),
    .rd_en   (pop_c),
    .rd_data (rd_entry),
    .count   (count)
  );

  assign id_pc     = rd_entry.pc;
  assign id_instr  = rd_entry.instr;
  assign ifq_count = count;

endmodule

// File: doc/core_ifq.md
# core_ifq

Instruction fetch queue between the fetch stage and the decode stage. It captures every completed fetch (PC plus instruction word) into a small synchronous FIFO and presents the entries in order to decode with a valid/ready handshake. When the queue is full it halts fetch, and on a control-flow redirect it discards all queued and in-flight instructions. This decouples memory-bus latency from decode stalls.

## Interface

Parameters:
- DEPTH, 4: number of entries; must be a power of two and at least 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- if_pc  in  32  PC of the fetched instruction.
- if_instr  in  32  fetched instruction word.
- if_busy  in  1  0 means if_pc/if_instr carry a completed fetch this cycle.
- if_halt  out  1  halt request to fetch; 1 while the queue is full.
- flush  in  1  redirect; discards queue contents and this cycle's fetch.
- id_valid  out  1  head entry is valid.
- id_pc  out  32  PC of head entry.
- id_instr  out  32  instruction word of head entry.
- id_ready  in  1  decode consumes the head entry when id_valid & id_ready.
- ifq_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- push = !if_busy & !flush & (count != DEPTH).
- pop = id_valid & id_ready & !flush.
- A push writes {if_pc, if_instr} at wr_ptr, then increments wr_ptr.
- A pop increments rd_ptr.
- count is updated by +push, -pop; a simultaneous push and pop leaves count unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
- A flush forces wr_ptr = rd_ptr = 0 and count = 0 on the next edge. It overrides push and pop in the same cycle.
- if_halt = (count == DEPTH). It depends only on registered state, with no combinational path from id_ready or if_busy.
- id_valid = (count != 0). id_pc/id_instr are read combinationally from the storage slot at rd_ptr.
- Fetch in progress when the queue fills: fetch reports if_busy=1 while halted. A non-busy fetch arriving while full is dropped and never written; this case is a bench assertion failure only if if_halt was already 1 in the previous cycle.
- There is no bypass. An instruction pushed in cycle N is visible to decode in cycle N+1, even when the queue was empty.
- Reset values: count=0, wr_ptr=0, rd_ptr=0, id_valid=0, if_halt=0, ifq_count=0. Storage contents are don't-care, but id_pc/id_instr must not be X-propagating in simulation, so storage is reset to 0.
- Reset asserted mid-operation empties the queue on the next edge, regardless of flush, push or pop.

## Timing

- Push-to-visible latency: 1 cycle.
- Pop takes effect at the edge; the next entry appears in the same cycle after the edge.
- Full to if_halt: asserted in the cycle after the push that fills the queue. Deasserted in the cycle after the first pop from full.
- Flush: the queue is empty (id_valid=0) in the cycle after flush is high. A fetch presented in that following cycle is accepted normally.
- Steady state: one push and one pop per cycle sustains full throughput, with no bubble at any occupancy between 1 and DEPTH-1.

## Structure

- The shared core package (i2d_core_pkg) holds:
  - typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ifq_entry_t;
  - localparam IFQ_DEPTH_DEFAULT = 4.
- One sub-module, i2d_sync_fifo:
  - generic parameterised-width/depth FIFO (ports wr_en, wr_data, rd_en, rd_data, count, clear);
  - core_ifq instantiates it with ifq_entry_t and adds the flush, halt and handshake gating around it.
- Expected size: about 150 lines for the FIFO plus the wrapper.

## Test plan

- Reset then idle: rst=1 for 2 cycles with if_busy=0 → id_valid=0, if_halt=0, ifq_count=0; no push during reset.
- Streaming: push PCs 0x0, 0x4, 0x8 on consecutive cycles with id_ready=1 → id_pc shows 0x0, 0x4, 0x8 in cycles 1, 2, 3; ifq_count never exceeds 1.
- Fill: id_ready=0 and 4 pushes (DEPTH=4) → ifq_count=4, if_halt=1 in the cycle after the 4th push. Then id_ready=1 for one cycle → if_halt=0 next cycle, and id_pc of the popped entry = the first PC pushed.
- Wrap-around: 10 pushes interleaved with pops, holding occupancy at 2 to 3 → output PC sequence is strictly ascending by 4 with no loss or duplication.
- Flush with simultaneous push and pop: queue holds 0x10, 0x14; flush=1 while if_pc=0x18 is non-busy and id_ready=1 → next cycle id_valid=0 and ifq_count=0, and 0x18 never appears. Push 0x100 the cycle after → id_pc=0x100 one cycle later.
- Reset mid-operation: queue at count 3, assert rst for 1 cycle → next cycle count=0, id_valid=0, if_halt=0.
